// File: rtl/wasm_operand_stack.sv
// rtl/wasm_operand_stack.sv - WASM operand/locals stack with integrated call-frame stack
// Owns sp, bp and frame depth; CALL zero-fills locals and RET copies results down over multiple cycles.
module wasm_operand_stack #(
   parameter int DATA_W = 128,
   parameter int DEPTH  = 256,
   parameter int FRAMES = 16,
   parameter int CNT_W  = 8,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        op_valid,
   output logic                        op_ready,
   input  logic [2:0]                  op,
   input  logic [DATA_W-1:0]           value_in,
   input  logic [ADDR_W-1:0]           offset,
   input  logic [CNT_W-1:0]            cnt_a,
   input  logic [CNT_W-1:0]            cnt_b,
   output logic [DATA_W-1:0]           val0,
   output logic [DATA_W-1:0]           val1,
   output logic                        out_valid,
   output logic [ADDR_W:0]             sp,
   output logic [ADDR_W:0]             bp,
   output logic [$clog2(FRAMES):0]     frame_depth,
   output logic                        err,
   output logic [2:0]                  err_code
);
   localparam int FD_W = $clog2(FRAMES) + 1;
   localparam int FI_W = $clog2(FRAMES);
   localparam int SPW  = ADDR_W + 1;
   // Wide enough that sp+nlocals and count compares can never wrap.
   localparam int EW   = (ADDR_W + 2 > CNT_W + 1) ? ADDR_W + 2 : CNT_W + 1;

   localparam logic [2:0] OP_PUSH = 3'd1, OP_POP1 = 3'd2, OP_POP2 = 3'd3, OP_LGET = 3'd4,
                          OP_LSET = 3'd5, OP_CALL = 3'd6, OP_RET  = 3'd7;

   typedef enum logic [1:0] {S_IDLE, S_ZERO, S_COPY} state_t;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [ADDR_W:0]   frm_q [FRAMES];

   state_t            state_q, state_d;
   logic [ADDR_W:0]   sp_q, sp_d, bp_q, bp_d, dst_q, dst_d;
   logic [ADDR_W-1:0] src_q, src_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [FD_W-1:0]   fd_q, fd_d;
   logic [DATA_W-1:0] val0_q, val0_d, val1_q, val1_d;
   logic              out_valid_q, out_valid_d, err_q, err_d;
   logic [2:0]        err_code_q, err_code_d;

   logic              mem_we, frm_we, err_set;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic [2:0]        code;

   logic [EW-1:0]     sp_e, bp_e, ca_e, cb_e, used_e, loc_e, sp_ca_e;
   logic [ADDR_W-1:0] sp_idx, spm1_idx, spm2_idx, loc_idx;
   logic [FD_W-1:0]   fd_m1;
   logic [ADDR_W:0]   saved_bp;

   always_comb begin
      sp_e     = EW'(sp_q);
      bp_e     = EW'(bp_q);
      ca_e     = EW'(cnt_a);
      cb_e     = EW'(cnt_b);
      used_e   = sp_e - bp_e;
      loc_e    = bp_e + EW'(offset);
      sp_ca_e  = sp_e - ca_e;
      sp_idx   = sp_q[ADDR_W-1:0];
      spm1_idx = sp_idx - ADDR_W'(1);
      spm2_idx = sp_idx - ADDR_W'(2);
      loc_idx  = bp_q[ADDR_W-1:0] + offset;
      fd_m1    = fd_q - FD_W'(1);
      saved_bp = frm_q[fd_m1[FI_W-1:0]];
   end

   always_comb begin
      state_d     = state_q;
      sp_d        = sp_q;
      bp_d        = bp_q;
      src_d       = src_q;
      dst_d       = dst_q;
      cnt_d       = cnt_q;
      fd_d        = fd_q;
      val0_d      = val0_q;
      val1_d      = val1_q;
      out_valid_d = 1'b0;
      err_d       = err_q;
      err_code_d  = err_code_q;
      mem_we      = 1'b0;
      mem_waddr   = sp_idx;
      mem_wdata   = '0;
      frm_we      = 1'b0;
      err_set     = 1'b0;
      code        = 3'd0;

      case (state_q)
         S_IDLE: if (op_valid) begin
            case (op)
               OP_PUSH: begin
                  if (sp_e >= EW'(DEPTH)) begin
                     err_set = 1'b1; code = 3'd1;
                  end else begin
                     mem_we = 1'b1; mem_wdata = value_in; sp_d = sp_q + SPW'(1);
                  end
               end
               OP_POP1: begin
                  if (used_e < EW'(1)) begin
                     err_set = 1'b1; code = 3'd2;
                  end else begin
                     val0_d = mem_q[spm1_idx]; out_valid_d = 1'b1; sp_d = sp_q - SPW'(1);
                  end
               end
               OP_POP2: begin
                  if (used_e < EW'(2)) begin
                     err_set = 1'b1; code = 3'd2;
                  end else begin
                     val0_d = mem_q[spm1_idx]; val1_d = mem_q[spm2_idx];
                     out_valid_d = 1'b1; sp_d = sp_q - SPW'(2);
                  end
               end
               OP_LGET: begin
                  if (loc_e >= sp_e) begin
                     err_set = 1'b1; code = 3'd3;
                  end else if (sp_e >= EW'(DEPTH)) begin
                     err_set = 1'b1; code = 3'd1;
                  end else begin
                     mem_we = 1'b1; mem_wdata = mem_q[loc_idx]; sp_d = sp_q + SPW'(1);
                  end
               end
               OP_LSET: begin
                  if (used_e < EW'(1)) begin
                     err_set = 1'b1; code = 3'd2;
                  end else if (loc_e >= sp_e - EW'(1)) begin
                     err_set = 1'b1; code = 3'd3;
                  end else begin
                     mem_we = 1'b1; mem_waddr = loc_idx; mem_wdata = mem_q[spm1_idx];
                     sp_d = sp_q - SPW'(1);
                  end
               end
               OP_CALL: begin
                  if (ca_e > used_e) begin
                     err_set = 1'b1; code = 3'd2;
                  end else if (fd_q >= FD_W'(FRAMES)) begin
                     err_set = 1'b1; code = 3'd4;
                  end else if (sp_e + cb_e > EW'(DEPTH)) begin
                     err_set = 1'b1; code = 3'd1;
                  end else begin
                     frm_we = 1'b1;
                     bp_d   = sp_ca_e[ADDR_W:0];
                     fd_d   = fd_q + FD_W'(1);
                     if (cnt_b != '0) begin
                        state_d = S_ZERO; cnt_d = cnt_b;
                     end
                  end
               end
               OP_RET: begin
                  if (fd_q == '0) begin
                     err_set = 1'b1; code = 3'd5;
                  end else if (ca_e > used_e) begin
                     err_set = 1'b1; code = 3'd2;
                  end else if (cnt_a == '0) begin
                     sp_d = bp_q; bp_d = saved_bp; fd_d = fd_m1;
                  end else begin
                     state_d = S_COPY;
                     src_d   = sp_ca_e[ADDR_W-1:0];
                     dst_d   = bp_q;
                     cnt_d   = cnt_a;
                  end
               end
               default: ;
            endcase
         end
         S_ZERO: begin
            mem_we = 1'b1;
            sp_d   = sp_q + SPW'(1);
            cnt_d  = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = S_IDLE;
         end
         S_COPY: begin
            mem_we    = 1'b1;
            mem_waddr = dst_q[ADDR_W-1:0];
            mem_wdata = mem_q[src_q];
            src_d     = src_q + ADDR_W'(1);
            dst_d     = dst_q + SPW'(1);
            cnt_d     = cnt_q - CNT_W'(1);
            // Last copy lands at bp+nresults-1, so the new sp is one past it.
            if (cnt_q == CNT_W'(1)) begin
               sp_d    = dst_q + SPW'(1);
               bp_d    = saved_bp;
               fd_d    = fd_m1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (err_set) begin
         err_d = 1'b1;
         if (!err_q) err_code_d = code;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         sp_q        <= '0;
         bp_q        <= '0;
         src_q       <= '0;
         dst_q       <= '0;
         cnt_q       <= '0;
         fd_q        <= '0;
         val0_q      <= '0;
         val1_q      <= '0;
         out_valid_q <= 1'b0;
         err_q       <= 1'b0;
         err_code_q  <= 3'd0;
      end else begin
         state_q     <= state_d;
         sp_q        <= sp_d;
         bp_q        <= bp_d;
         src_q       <= src_d;
         dst_q       <= dst_d;
         cnt_q       <= cnt_d;
         fd_q        <= fd_d;
         val0_q      <= val0_d;
         val1_q      <= val1_d;
         out_valid_q <= out_valid_d;
         err_q       <= err_d;
         err_code_q  <= err_code_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && mem_we) mem_q[mem_waddr] <= mem_wdata;
      if (!rst && frm_we) frm_q[fd_q[FI_W-1:0]] <= bp_q;
   end

   assign op_ready    = (state_q == S_IDLE);
   assign val0        = val0_q;
   assign val1        = val1_q;
   assign out_valid   = out_valid_q;
   assign sp          = sp_q;
   assign bp          = bp_q;
   assign frame_depth = fd_q;
   assign err         = err_q;
   assign err_code    = err_code_q;
endmodule

// File: doc/wasm_operand_stack.md
Name: wasm_operand_stack

Overview:
- Parametrised operand/locals stack for the WASM accelerator datapath, with an integrated call-frame stack.
- Replaces the single-value stack plus separate base-pointer unit with one block that:
  - handles push/pop/dual-pop;
  - handles bp-relative local access (local.get/local.set);
  - runs multi-cycle CALL sequencing (local zero-fill) and RET sequencing (result copy-down).
- The control unit issues one op per handshake. The block owns sp, bp and frame depth.

Parameters:
- DATA_W, 128, width of one stack slot (value).
- DEPTH, 256, number of operand/local slots (power of two).
- FRAMES, 16, call-frame stack depth (saved bp entries).
- CNT_W, 8, width of the count fields (nparams, nlocals, nresults).
- ADDR_W, $clog2(DEPTH), slot index width; sp/bp are ADDR_W+1 bits.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- op_valid, input, 1, op request.
- op_ready, output, 1, block can accept an op this cycle.
- op, input, 3, opcode: 0 NOP, 1 PUSH, 2 POP1, 3 POP2, 4 LGET, 5 LSET, 6 CALL, 7 RET.
- value_in, input, DATA_W, PUSH data.
- offset, input, ADDR_W, local index for LGET/LSET (relative to bp).
- cnt_a, input, CNT_W, CALL: nparams; RET: nresults.
- cnt_b, input, CNT_W, CALL: nlocals (non-param).
- val0, output, DATA_W, popped top value.
- val1, output, DATA_W, popped second value (POP2 only).
- out_valid, output, 1, 1-cycle pulse, val0/val1 valid.
- sp, output, ADDR_W+1, stack pointer (next free slot).
- bp, output, ADDR_W+1, current frame base.
- frame_depth, output, $clog2(FRAMES)+1, number of saved frames.
- err, output, 1, sticky error flag.
- err_code, output, 3, first error: 1 overflow, 2 underflow, 3 local range, 4 frame overflow, 5 frame underflow.

Behaviour:
- Reset values: op_ready=1, out_valid=0, val0=val1=0, sp=bp=0, frame_depth=0, err=0, err_code=0, FSM=IDLE. Slot contents are not reset.
- Storage is a flop array with combinational reads. At most one slot write per cycle.
- Handshake: an op is accepted when op_valid && op_ready. op_ready=1 only in IDLE. NOP is accepted with no effect.
- Results are registered. out_valid rises the cycle after POP1/POP2 acceptance, for 1 cycle.
- PUSH: needs sp<DEPTH, else error 1. Writes mem[sp]=value_in, sp+=1.
- POP1: needs sp-bp>=1, else error 2. val0=mem[sp-1], sp-=1.
- POP2: needs sp-bp>=2, else error 2. val0=mem[sp-1], val1=mem[sp-2], sp-=2.
- LGET: needs bp+offset<sp, else error 3; then needs sp<DEPTH, else error 1. Writes mem[sp]=mem[bp+offset], sp+=1.
- LSET: needs sp-bp>=1, else error 2; then needs bp+offset<sp-1, else error 3. Writes mem[bp+offset]=mem[sp-1], sp-=1.
- CALL: needs nparams<=sp-bp, else error 2; needs frame_depth<FRAMES, else error 4; needs sp+nlocals<=DEPTH, else error 1.
  - Accept cycle: push bp onto the frame stack, bp<=sp-nparams, frame_depth+=1.
  - If nlocals==0: return to IDLE; sp unchanged.
  - Else enter ZERO: write 0 to mem[sp] and increment sp each cycle, nlocals cycles, then IDLE.
  - op_ready=0 throughout ZERO.
- RET: needs frame_depth>0, else error 5; needs nresults<=sp-bp, else error 2.
  - If nresults==0: single cycle; sp<=bp, bp<=saved bp, frame_depth-=1.
  - Else enter COPY with src=sp-nresults, dst=bp, cnt=nresults. Each cycle: mem[dst]<=mem[src], src++, dst++, cnt--.
  - On the last copy cycle: sp<=bp+nresults, bp<=saved bp, frame_depth-=1, next state IDLE.
  - src==dst is legal: the copy is a no-op write, still nresults cycles.
- Error checks use the listed priority order. An erroring op is consumed and has no state effect. err is set, err_code is latched only if err was 0, and stays until rst.
- Boundaries:
  - sp==DEPTH is full and legal.
  - frame_depth==FRAMES is full and legal.
  - Arithmetic is done at ADDR_W+2 bits, so sp+nlocals cannot wrap.
- rst mid-ZERO/COPY: FSM returns to IDLE immediately; all registers take reset values.

Test Plan:
- DEPTH=8. PUSH 0x11, PUSH 0x22, POP2 -> out_valid 1 cycle later, val0=0x22, val1=0x11, sp=0.
- PUSH 8 values, then PUSH 9th -> sp=8, err=1, err_code=1, slot 7 unchanged. Then POP1 -> val0=8th value, sp=7.
- PUSH A,B; CALL nparams=2 nlocals=3 -> bp=0, sp ramps 2→5 over 3 cycles with op_ready=0, frame_depth=1. LGET offset=4 pushes 0; LGET offset=1 pushes B.
- In the frame above, push X,Y (sp=7); RET nresults=2 -> 2 copy cycles; mem[0]=X, mem[1]=Y, sp=2, bp=0, frame_depth=0.
- RET with frame_depth=0 -> err_code=5. A later POP1 underflow leaves err_code=5 (first error is kept).
- Assert rst in the 2nd ZERO cycle of CALL nlocals=4 -> next cycle sp=0, bp=0, frame_depth=0, op_ready=1, err=0.
